// File: rtl/sdio_blkseq.sv
// sdio_blkseq: host-side SDIO block-transfer sequencer.
//
// Takes one read/write request (start block, block count), issues
// CMD17/18/24/25 to the command engine, gates the RX/TX data engines one block
// at a time, waits out DAT0 busy after written blocks and closes multi-block
// transfers with CMD12. Holds no data itself.
//
// Parameters:
//   OPT_HCS    1: argument is the block number; 0: argument is the byte address
//   LGTIMEOUT  log2 of the clocks allowed for a reply, block or busy phase
// Optional feature macro:
//   SDIO_BLKSEQ_TIMEOUT_EN  defined: phase timeout counter and error code 4
//                           undefined: every phase waits indefinitely
// Ports:
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_req/i_write/i_addr/i_nblocks   request (taken only when idle)
//   o_busy/o_done/o_err/o_errcode    status; o_done is a one-cycle strobe
//   o_cmd_stb/o_cmd/o_cmd_arg, i_cmd_ack/i_cmd_done/i_cmd_err   command engine
//   o_rx_en/o_tx_en, i_blk_done/i_blk_err   data engines
//   i_dat0                     synchronized DAT0, low while the card is busy
// Error codes: 0 ok, 1 zero count, 2 command, 3 block, 4 timeout, 5 stop.
module sdio_blkseq #(
  parameter bit          OPT_HCS   = 1'b1,
  parameter int unsigned LGTIMEOUT = 20
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [15:0] i_nblocks,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_errcode,
  output logic        o_cmd_stb,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_arg,
  input  logic        i_cmd_ack,
  input  logic        i_cmd_done,
  input  logic        i_cmd_err,
  output logic        o_rx_en,
  output logic        o_tx_en,
  input  logic        i_blk_done,
  input  logic        i_blk_err,
  input  logic        i_dat0
);

  typedef enum logic [3:0] {
    StIdle, StCmd, StReply, StData, StWbusy, StStop, StStopReply, StSbusy, StDone
  } state_e;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrZero    = 3'd1;
  localparam logic [2:0] ErrCmd     = 3'd2;
  localparam logic [2:0] ErrBlk     = 3'd3;
  localparam logic [2:0] ErrTimeout = 3'd4;
  localparam logic [2:0] ErrStop    = 3'd5;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        multi_q, multi_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [2:0]  code_q, code_d;
  logic        gap_q, gap_d;        // enable dropped for the cycle after a block
  logic        hi_q, hi_d;          // DAT0 was high last cycle in a busy state
  logic        pend_q, pend_d;      // read block finished before the reply
  logic        pend_err_q, pend_err_d;

  logic        blk_ev, blk_err_ev, tmo_sat;

  // Timeout counter restarts on every state change and on every finished block.
`ifdef SDIO_BLKSEQ_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;

  assign tmo_sat = &tmo_q;

  always_comb begin
    tmo_d = tmo_sat ? tmo_q : tmo_q + 1'b1;
    if ((state_d != state_q) || i_blk_done) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic [LGTIMEOUT-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_sat    = 1'b0;
`endif

  // A block completed while the read command was still in flight is replayed
  // in the first DATA cycle.
  assign blk_ev     = i_blk_done || pend_q;
  assign blk_err_ev = pend_q ? pend_err_q : i_blk_err;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    multi_d    = multi_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    code_d     = code_q;
    gap_d      = 1'b0;
    hi_d       = 1'b0;
    pend_d     = pend_q;
    pend_err_d = pend_err_q;

    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          if (i_nblocks == 16'd0) begin
            code_d  = ErrZero;
            state_d = StDone;
          end else begin
            write_d = i_write;
            multi_d = (i_nblocks != 16'd1);
            cnt_d   = i_nblocks;
            code_d  = ErrNone;
            pend_d  = 1'b0;
            if (i_nblocks == 16'd1) begin
              cmd_d = i_write ? 6'd24 : 6'd17;
            end else begin
              cmd_d = i_write ? 6'd25 : 6'd18;
            end
            arg_d   = OPT_HCS ? i_addr : {i_addr[22:0], 9'h000};
            state_d = StCmd;
          end
        end
      end

      StCmd: begin
        if (!write_q && i_blk_done) begin
          pend_d     = 1'b1;
          pend_err_d = i_blk_err;
        end
        if (i_cmd_ack) begin
          state_d = StReply;
        end
      end

      StReply: begin
        if (!write_q && i_blk_done) begin
          pend_d     = 1'b1;
          pend_err_d = i_blk_err;
        end
        if (i_cmd_done) begin
          if (i_cmd_err) begin
            code_d  = ErrCmd;
            state_d = StDone;
          end else begin
            state_d = StData;
          end
        end else if (tmo_sat && !i_blk_done) begin
          // The command never completed, so there is nothing to stop.
          code_d  = ErrTimeout;
          state_d = StDone;
        end
      end

      StData: begin
        if (blk_ev) begin
          gap_d  = 1'b1;
          pend_d = 1'b0;
          if (blk_err_ev) begin
            code_d  = ErrBlk;
            state_d = multi_q ? StStop : StDone;
          end else begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              if (multi_q) begin
                state_d = StStop;
              end else begin
                state_d = write_q ? StWbusy : StDone;
              end
            end else if (write_q) begin
              state_d = StWbusy;
            end
          end
        end else if (tmo_sat) begin
          code_d  = ErrTimeout;
          state_d = multi_q ? StStop : StDone;
        end
      end

      StWbusy: begin
        hi_d = i_dat0;
        if (hi_q && i_dat0) begin
          state_d = (cnt_q == 16'd0) ? StDone : StData;
        end else if (tmo_sat && !i_blk_done) begin
          code_d  = ErrTimeout;
          state_d = multi_q ? StStop : StDone;
        end
      end

      StStop: begin
        if (i_cmd_ack) begin
          state_d = StStopReply;
        end
      end

      StStopReply: begin
        if (i_cmd_done) begin
          if (i_cmd_err) begin
            // An earlier failure is the more useful cause to report.
            if (code_q == ErrNone) begin
              code_d = ErrStop;
            end
            state_d = StDone;
          end else begin
            state_d = StSbusy;
          end
        end
      end

      StSbusy: begin
        hi_d = i_dat0;
        if (hi_q && i_dat0) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_d == StStop) && (state_q != StStop)) begin
      cmd_d = 6'd12;
      arg_d = 32'h0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      multi_q    <= 1'b0;
      cnt_q      <= 16'd0;
      cmd_q      <= 6'd0;
      arg_q      <= 32'h0;
      code_q     <= ErrNone;
      gap_q      <= 1'b0;
      hi_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      multi_q    <= multi_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      code_q     <= code_d;
      gap_q      <= gap_d;
      hi_q       <= hi_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
    end
  end

  always_comb begin
    o_busy    = (state_q != StIdle) && (state_q != StDone);
    o_done    = (state_q == StDone);
    o_err     = (state_q == StDone) && (code_q != ErrNone);
    o_errcode = code_q;
    o_cmd_stb = (state_q == StCmd) || (state_q == StStop);
    o_cmd     = cmd_q;
    o_cmd_arg = arg_q;
    // Reads open the RX engine while the command is out: data can beat the reply.
    o_rx_en   = !write_q && !gap_q &&
                ((state_q == StCmd) || (state_q == StReply) || (state_q == StData));
    o_tx_en   = write_q && !gap_q && (state_q == StData);
  end

endmodule

// File: tb/tb_sdio_blkseq.sv
// Directed self-checking bench for sdio_blkseq. Two instances share stimulus:
// u_dut (byte addressing) is fully checked; u_dut_hcs (block addressing) is
// used for the block-address argument.
module tb_sdio_blkseq;

  localparam int unsigned LgTimeout = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_write;
  logic [31:0] i_addr;
  logic [15:0] i_nblocks;
  logic        i_cmd_ack, i_cmd_done, i_cmd_err;
  logic        i_blk_done, i_blk_err, i_dat0;

  logic        o_busy, o_done, o_err, o_cmd_stb, o_rx_en, o_tx_en;
  logic [2:0]  o_errcode;
  logic [5:0]  o_cmd;
  logic [31:0] o_cmd_arg;

  logic        b_busy, b_done, b_err, b_cmd_stb, b_rx_en, b_tx_en;
  logic [2:0]  b_errcode;
  logic [5:0]  b_cmd;
  logic [31:0] b_cmd_arg;

  always #5 clk = ~clk;

  sdio_blkseq #(.OPT_HCS(1'b0), .LGTIMEOUT(LgTimeout)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(i_req), .i_write(i_write), .i_addr(i_addr),
    .i_nblocks(i_nblocks), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_errcode(o_errcode), .o_cmd_stb(o_cmd_stb), .o_cmd(o_cmd), .o_cmd_arg(o_cmd_arg),
    .i_cmd_ack(i_cmd_ack), .i_cmd_done(i_cmd_done), .i_cmd_err(i_cmd_err),
    .o_rx_en(o_rx_en), .o_tx_en(o_tx_en), .i_blk_done(i_blk_done), .i_blk_err(i_blk_err),
    .i_dat0(i_dat0)
  );

  sdio_blkseq #(.OPT_HCS(1'b1), .LGTIMEOUT(LgTimeout)) u_dut_hcs (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(i_req), .i_write(i_write), .i_addr(i_addr),
    .i_nblocks(i_nblocks), .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
    .o_errcode(b_errcode), .o_cmd_stb(b_cmd_stb), .o_cmd(b_cmd), .o_cmd_arg(b_cmd_arg),
    .i_cmd_ack(i_cmd_ack), .i_cmd_done(i_cmd_done), .i_cmd_err(i_cmd_err),
    .o_rx_en(b_rx_en), .o_tx_en(b_tx_en), .i_blk_done(i_blk_done), .i_blk_err(i_blk_err),
    .i_dat0(i_dat0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters on u_dut: command handshakes, CMD12s, enable windows.
  int   n_hs = 0, n_cmd12 = 0, n_tx_win = 0, n_rx_win = 0;
  logic tx_prev = 1'b0, rx_prev = 1'b0;

  always @(posedge clk) begin
    if (o_cmd_stb && i_cmd_ack) begin
      n_hs <= n_hs + 1;
      if (o_cmd == 6'd12) n_cmd12 <= n_cmd12 + 1;
    end
    if (o_tx_en && !tx_prev) n_tx_win <= n_tx_win + 1;
    if (o_rx_en && !rx_prev) n_rx_win <= n_rx_win + 1;
    tx_prev <= o_tx_en;
    rx_prev <= o_rx_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic wr, input logic [31:0] addr, input logic [15:0] n);
    i_req = 1'b1; i_write = wr; i_addr = addr; i_nblocks = n;
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic blk(input logic err);
    i_blk_done = 1'b1; i_blk_err = err;
    @(negedge clk);
    i_blk_done = 1'b0; i_blk_err = 1'b0;
  endtask

  // Wait for the strobe, check cmd/arg, ack, then return the reply 3 cycles later.
  task automatic issue_cmd(input string tag, input logic [5:0] ecmd,
                           input logic [31:0] earg, input logic err);
    int k = 0;
    while (!o_cmd_stb && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_stb"}, 32'(o_cmd_stb), 32'd1);
    check({tag, "_cmd"}, 32'(o_cmd), 32'(ecmd));
    check({tag, "_arg"}, o_cmd_arg, earg);
    i_cmd_ack = 1'b1;
    @(negedge clk);
    i_cmd_ack = 1'b0;
    check({tag, "_stb_drop"}, 32'(o_cmd_stb), 32'd0);
    repeat (3) @(negedge clk);
    i_cmd_done = 1'b1; i_cmd_err = err;
    @(negedge clk);
    i_cmd_done = 1'b0; i_cmd_err = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic eerr, input logic [2:0] ecode);
    int k = 0;
    while (!o_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(o_done), 32'd1);
    check({tag, "_err"}, 32'(o_err), 32'(eerr));
    check({tag, "_code"}, 32'(o_errcode), 32'(ecode));
    check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int hs0, c120, tx0, rx0;
    rst_n = 1'b0;
    i_req = 1'b0; i_write = 1'b0; i_addr = 32'h0; i_nblocks = 16'd0;
    i_cmd_ack = 1'b0; i_cmd_done = 1'b0; i_cmd_err = 1'b0;
    i_blk_done = 1'b0; i_blk_err = 1'b0; i_dat0 = 1'b1;
    #3;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_code", 32'(o_errcode), 32'd0);
    check("rst_stb", 32'(o_cmd_stb), 32'd0);
    check("rst_cmd", 32'(o_cmd), 32'd0);
    check("rst_arg", o_cmd_arg, 32'd0);
    check("rst_rx", 32'(o_rx_en), 32'd0);
    check("rst_tx", 32'(o_tx_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read one block at 5: CMD17, single RX window, no CMD12.
    hs0 = n_hs; c120 = n_cmd12; tx0 = n_tx_win; rx0 = n_rx_win;
    start(1'b0, 32'd5, 16'd1);
    check("rd1_busy", 32'(o_busy), 32'd1);
    check("rd1_rx_in_cmd", 32'(o_rx_en), 32'd1);
    check("rd1_hcs_cmd", 32'(b_cmd), 32'd17);
    check("rd1_hcs_arg", b_cmd_arg, 32'd5);
    repeat (2) @(negedge clk);
    check("rd1_stb_held", 32'(o_cmd_stb), 32'd1);
    issue_cmd("rd1", 6'd17, 32'hA00, 1'b0);
    i_req = 1'b1; i_nblocks = 16'd0;       // ignored while busy
    @(negedge clk);
    i_req = 1'b0;
    check("rd1_rx_data", 32'(o_rx_en), 32'd1);
    check("rd1_tx_data", 32'(o_tx_en), 32'd0);
    blk(1'b0);
    wait_done("rd1", 1'b0, 3'd0);
    check("rd1_hs", 32'(n_hs - hs0), 32'd1);
    check("rd1_cmd12", 32'(n_cmd12 - c120), 32'd0);
    check("rd1_rx_win", 32'(n_rx_win - rx0), 32'd1);
    check("rd1_tx_win", 32'(n_tx_win - tx0), 32'd0);

    // Write three blocks at 2, byte addressing: CMD25 arg 0x400, busy gaps, CMD12.
    hs0 = n_hs; c120 = n_cmd12; tx0 = n_tx_win;
    start(1'b1, 32'd2, 16'd3);
    check("wr3_rx", 32'(o_rx_en), 32'd0);
    issue_cmd("wr3", 6'd25, 32'h400, 1'b0);
    for (int b = 0; b < 3; b++) begin
      check("wr3_tx_on", 32'(o_tx_en), 32'd1);
      i_dat0 = 1'b0;
      blk(1'b0);
      check("wr3_tx_off", 32'(o_tx_en), 32'd0);
      if (b < 2) begin
        repeat (2) @(negedge clk);
        i_dat0 = 1'b1;                      // single-cycle high is not enough
        @(negedge clk);
        i_dat0 = 1'b0;
        @(negedge clk);
        check("wr3_glitch", 32'(o_tx_en), 32'd0);
        @(negedge clk);
        i_dat0 = 1'b1;
        @(negedge clk);
        check("wr3_hi1", 32'(o_tx_en), 32'd0);
        @(negedge clk);
        check("wr3_hi2", 32'(o_tx_en), 32'd1);
        @(negedge clk);
      end
    end
    issue_cmd("wr3_stop", 6'd12, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("wr3_sbusy_wait", 32'(o_done), 32'd0);
    i_dat0 = 1'b1;
    @(negedge clk);
    check("wr3_sbusy1", 32'(o_done), 32'd0);
    @(negedge clk);
    check("wr3_sbusy2", 32'(o_done), 32'd1);
    wait_done("wr3", 1'b0, 3'd0);
    check("wr3_tx_win", 32'(n_tx_win - tx0), 32'd3);
    check("wr3_hs", 32'(n_hs - hs0), 32'd2);
    check("wr3_cmd12", 32'(n_cmd12 - c120), 32'd1);

    // Zero block count: immediate error completion, no command.
    hs0 = n_hs;
    start(1'b0, 32'd9, 16'd0);
    check("zero_done", 32'(o_done), 32'd1);
    check("zero_err", 32'(o_err), 32'd1);
    check("zero_code", 32'(o_errcode), 32'd1);
    check("zero_busy", 32'(o_busy), 32'd0);
    check("zero_stb", 32'(o_cmd_stb), 32'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(o_done), 32'd0);
    check("zero_hs", 32'(n_hs - hs0), 32'd0);

    // Read four blocks at 7, CRC error on block 2: CMD12, code 3.
    c120 = n_cmd12;
    start(1'b0, 32'd7, 16'd4);
    issue_cmd("rd4", 6'd18, 32'hE00, 1'b0);
    @(negedge clk);
    blk(1'b0);
    check("rd4_gap", 32'(o_rx_en), 32'd0);
    @(negedge clk);
    check("rd4_gap_end", 32'(o_rx_en), 32'd1);
    repeat (3) @(negedge clk);
    blk(1'b1);
    check("rd4_rx_after_err", 32'(o_rx_en), 32'd0);
    issue_cmd("rd4_stop", 6'd12, 32'h0, 1'b0);
    check("rd4_rx_stop", 32'(o_rx_en), 32'd0);
    wait_done("rd4", 1'b1, 3'd3);
    check("rd4_cmd12", 32'(n_cmd12 - c120), 32'd1);

    // CMD18 reply error: code 2, no CMD12, no TX.
    hs0 = n_hs; c120 = n_cmd12; tx0 = n_tx_win;
    start(1'b0, 32'd3, 16'd2);
    issue_cmd("rderr", 6'd18, 32'h600, 1'b1);
    check("rderr_rx", 32'(o_rx_en), 32'd0);
    wait_done("rderr", 1'b1, 3'd2);
    check("rderr_hs", 32'(n_hs - hs0), 32'd1);
    check("rderr_cmd12", 32'(n_cmd12 - c120), 32'd0);
    check("rderr_tx_win", 32'(n_tx_win - tx0), 32'd0);

    // Asynchronous reset mid-write: outputs clear at once, no CMD12 follows.
    hs0 = n_hs;
    start(1'b1, 32'd4, 16'd2);
    issue_cmd("rst", 6'd25, 32'h800, 1'b0);
    check("rst_mid_tx", 32'(o_tx_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_tx_off", 32'(o_tx_en), 32'd0);
    check("rst_mid_cmd", 32'(o_cmd), 32'd0);
    check("rst_mid_arg", o_cmd_arg, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_stb", 32'(o_cmd_stb), 32'd0);
    check("rst_mid_hs", 32'(n_hs - hs0), 32'd1);

`ifdef SDIO_BLKSEQ_TIMEOUT_EN
    // Single write with DAT0 stuck low: timeout after 2**8 clocks, code 4.
    begin
      int k = 0;
      start(1'b1, 32'd1, 16'd1);
      issue_cmd("tmo", 6'd24, 32'h200, 1'b0);
      i_dat0 = 1'b0;
      blk(1'b0);
      while (!o_done && k < 1000) begin
        @(negedge clk);
        k++;
      end
      check("tmo_cycles", 32'(k), 32'd256);
      wait_done("tmo", 1'b1, 3'd4);
      i_dat0 = 1'b1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
